// File: rtl/pc_ctrl.sv
// Fetch-side PC owner. It issues fetch requests, applies execute-stage redirects and holds,
// and drives flush/stall for IF/ID and ID/EX. Optional macro: PC_MISALIGN_TRAP_EN (misaligned-redirect trap).
module pc_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_i,
    output logic        fetch_req_o,
    output logic [31:0] fetch_addr_o,
    input  logic        fetch_gnt_i,
    output logic        inst_valid_o,
    output logic        flush_o,
`ifdef PC_MISALIGN_TRAP_EN
    output logic        misalign_o,
`endif
    output logic        stall_o
);

    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
`ifdef PC_MISALIGN_TRAP_EN
    localparam logic [1:0] TRAP  = 2'd3;
`endif

    // The redirect cycle itself is the first flush cycle, so FLUSH needs FLUSH_CYCLES-1 more cycles.
    localparam logic [1:0] CNT_LOAD = (FLUSH_CYCLES > 1) ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    logic [1:0]  state, state_nx;
    logic [1:0]  cnt, cnt_nx;
    logic [31:0] pc, pc_nx;
    logic        req, flush, stall, bad_jump;
    logic [31:0] target;

    assign target = {jump_addr_i[31:2], 2'b00};

`ifdef PC_MISALIGN_TRAP_EN
    assign bad_jump = jump_en_i & (|jump_addr_i[1:0]);
`else
    logic unused_addr_lo;
    assign unused_addr_lo = ^jump_addr_i[1:0];
    assign bad_jump       = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = pc;
        req      = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        case (state)
            BOOT: state_nx = RUN;
            RUN: begin
                if (jump_en_i) begin
                    if (bad_jump) begin
`ifdef PC_MISALIGN_TRAP_EN
                        state_nx = TRAP;
`endif
                    end else begin
                        flush = 1'b1;
                        pc_nx = target;
                        if (FLUSH_CYCLES > 1) begin
                            state_nx = FLUSH;
                            cnt_nx   = CNT_LOAD;
                        end
                    end
                end else if (hold_flag_i) begin
                    stall = 1'b1;
                end else begin
                    req = 1'b1;
                    if (fetch_gnt_i) pc_nx = pc + 32'd4;
                    else             stall = 1'b1;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (jump_en_i) begin
                    if (bad_jump) begin
`ifdef PC_MISALIGN_TRAP_EN
                        state_nx = TRAP;
`endif
                    end else begin
                        // A redirect during flush restarts the flush window at the new target.
                        pc_nx  = target;
                        cnt_nx = CNT_LOAD;
                    end
                end else if (cnt == 2'd0) begin
                    state_nx = RUN;
                end else begin
                    cnt_nx = cnt - 2'd1;
                end
            end
`ifdef PC_MISALIGN_TRAP_EN
            TRAP: stall = 1'b1;
`endif
            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= BOOT;
            cnt   <= 2'd0;
            pc    <= RESET_PC;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pc    <= pc_nx;
        end
    end

    assign fetch_req_o  = req;
    assign fetch_addr_o = pc;
    assign flush_o      = flush;
    assign stall_o      = stall;
    assign inst_valid_o = req & fetch_gnt_i & ~flush;
`ifdef PC_MISALIGN_TRAP_EN
    assign misalign_o   = (state == TRAP);
`endif

endmodule

// File: tb/tb_pc_ctrl.sv
// Directed vector bench for pc_ctrl (default parameters, macro undefined): a table of
// per-cycle inputs/expected outputs plus a hand-written asynchronous-reset-in-flush sequence.
module tb_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_i, hold_flag_i, fetch_gnt_i;
    logic [31:0] jump_addr_i;
    logic        fetch_req_o, inst_valid_o, flush_o, stall_o;
    logic [31:0] fetch_addr_o;
`ifdef PC_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pc_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .jump_en_i    (jump_en_i),
        .jump_addr_i  (jump_addr_i),
        .hold_flag_i  (hold_flag_i),
        .fetch_req_o  (fetch_req_o),
        .fetch_addr_o (fetch_addr_o),
        .fetch_gnt_i  (fetch_gnt_i),
        .inst_valid_o (inst_valid_o),
        .flush_o      (flush_o),
`ifdef PC_MISALIGN_TRAP_EN
        .misalign_o   (misalign_o),
`endif
        .stall_o      (stall_o)
    );

    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic        hold;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic        flush;
        logic        stall;
    } vec_t;

    localparam int NV = 29;
    vec_t vecs[NV];

    function automatic vec_t mk(logic j, logic [31:0] ja, logic h, logic g,
                                logic r, logic [31:0] a, logic v, logic f, logic s);
        vec_t t;
        t.jump = j; t.jaddr = ja; t.hold = h; t.gnt = g;
        t.req = r; t.addr = a; t.valid = v; t.flush = f; t.stall = s;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic r, input logic [31:0] a,
                           input logic v, input logic f, input logic s);
        chk({tag, " req"},   {31'd0, fetch_req_o},  {31'd0, r});
        chk({tag, " addr"},  fetch_addr_o,          a);
        chk({tag, " valid"}, {31'd0, inst_valid_o}, {31'd0, v});
        chk({tag, " flush"}, {31'd0, flush_o},      {31'd0, f});
        chk({tag, " stall"}, {31'd0, stall_o},      {31'd0, s});
    endtask

    initial begin
        //             jump addr          hold gnt | req addr          vld flush stall
        vecs[0]  = mk(1, 32'h200,        0, 1,    0, 32'h0,          0, 0, 0); // BOOT ignores jump
        vecs[1]  = mk(0, 32'h0,          0, 1,    1, 32'h0,          1, 0, 0);
        vecs[2]  = mk(0, 32'h0,          0, 1,    1, 32'h4,          1, 0, 0);
        vecs[3]  = mk(0, 32'h0,          0, 1,    1, 32'h8,          1, 0, 0);
        vecs[4]  = mk(0, 32'h0,          0, 1,    1, 32'hC,          1, 0, 0);
        vecs[5]  = mk(1, 32'h100,        0, 1,    0, 32'h10,         0, 1, 0);
        vecs[6]  = mk(0, 32'h0,          1, 1,    0, 32'h100,        0, 1, 0); // hold ignored in FLUSH
        vecs[7]  = mk(0, 32'h0,          0, 1,    1, 32'h100,        1, 0, 0);
        vecs[8]  = mk(1, 32'h40,         1, 1,    0, 32'h104,        0, 1, 0); // jump beats hold
        vecs[9]  = mk(0, 32'h0,          0, 1,    0, 32'h40,         0, 1, 0);
        vecs[10] = mk(0, 32'h0,          1, 1,    0, 32'h40,         0, 0, 1); // gnt without req ignored
        vecs[11] = mk(0, 32'h0,          1, 0,    0, 32'h40,         0, 0, 1);
        vecs[12] = mk(0, 32'h0,          1, 1,    0, 32'h40,         0, 0, 1);
        vecs[13] = mk(0, 32'h0,          0, 0,    1, 32'h40,         0, 0, 1);
        vecs[14] = mk(0, 32'h0,          0, 1,    1, 32'h40,         1, 0, 0);
        vecs[15] = mk(0, 32'h0,          0, 1,    1, 32'h44,         1, 0, 0);
        vecs[16] = mk(1, 32'h102,        0, 1,    0, 32'h48,         0, 1, 0); // low bits cleared
        vecs[17] = mk(0, 32'h0,          0, 1,    0, 32'h100,        0, 1, 0);
        vecs[18] = mk(0, 32'h0,          0, 1,    1, 32'h100,        1, 0, 0);
        vecs[19] = mk(1, 32'hFFFF_FFFF,  0, 1,    0, 32'h104,        0, 1, 0);
        vecs[20] = mk(0, 32'h0,          0, 1,    0, 32'hFFFF_FFFC,  0, 1, 0);
        vecs[21] = mk(0, 32'h0,          0, 0,    1, 32'hFFFF_FFFC,  0, 0, 1);
        vecs[22] = mk(0, 32'h0,          0, 0,    1, 32'hFFFF_FFFC,  0, 0, 1);
        vecs[23] = mk(0, 32'h0,          0, 1,    1, 32'hFFFF_FFFC,  1, 0, 0);
        vecs[24] = mk(0, 32'h0,          0, 1,    1, 32'h0,          1, 0, 0); // wrapped
        vecs[25] = mk(1, 32'h300,        0, 1,    0, 32'h4,          0, 1, 0);
        vecs[26] = mk(1, 32'h500,        0, 1,    0, 32'h300,        0, 1, 0); // re-redirect in FLUSH
        vecs[27] = mk(0, 32'h0,          0, 1,    0, 32'h500,        0, 1, 0);
        vecs[28] = mk(0, 32'h0,          0, 1,    1, 32'h500,        1, 0, 0);

        rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0; fetch_gnt_i = 1'b1;
        #12;
        chk_all("reset", 0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            jump_en_i   = vecs[i].jump;
            jump_addr_i = vecs[i].jaddr;
            hold_flag_i = vecs[i].hold;
            fetch_gnt_i = vecs[i].gnt;
            @(negedge clk);
            chk_all($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr,
                    vecs[i].valid, vecs[i].flush, vecs[i].stall);
            @(posedge clk); #1;
        end

        // Asynchronous reset in the middle of a flush window.
        jump_en_i = 1'b1; jump_addr_i = 32'h600; hold_flag_i = 1'b0; fetch_gnt_i = 1'b1;
        @(negedge clk);
        chk_all("rjump", 0, 32'h504, 0, 1, 0);
        @(posedge clk); #1;
        jump_en_i = 1'b0;
        #2;
        chk_all("in_flush", 0, 32'h600, 0, 1, 0);
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        chk_all("rst_held", 0, 32'h0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all("boot2", 0, 32'h0, 0, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_all("resume0", 1, 32'h0, 1, 0, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk_all("resume4", 1, 32'h4, 1, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
# pc_ctrl

Fetch-side control block: owns the program counter, issues instruction-fetch requests to instruction memory, and consumes the redirect/hold outputs of the execute stage (`jump_en`, `jump_addr`, `hold_flag`). It generates the flush and stall controls for the IF/ID and ID/EX pipeline registers. It sits between the execute stage and the instruction ROM/bus, closing the loop from branch resolution back to fetch.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset.
- `FLUSH_CYCLES`, 2, cycles `flush_o` stays high per redirect, counting the redirect cycle. Legal range 1..3.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `jump_en_i`  in  1  redirect request from execute.
- `jump_addr_i`  in  32  redirect target from execute.
- `hold_flag_i`  in  1  execute requests fetch hold.
- `fetch_req_o`  out  1  fetch request valid to instruction memory.
- `fetch_addr_o`  out  32  current PC; the fetch address.
- `fetch_gnt_i`  in  1  memory accepts `fetch_addr_o` this cycle.
- `inst_valid_o`  out  1  IF/ID may capture the returned instruction.
- `flush_o`  out  1  clear IF/ID and ID/EX contents.
- `stall_o`  out  1  IF/ID and ID/EX hold their contents.
- `misalign_o`  out  1  misaligned redirect trap. Only present with `PC_MISALIGN_TRAP_EN`.

## Operation
- States: BOOT, RUN, FLUSH, TRAP. TRAP exists only with the macro.
- **Reset (asynchronous, immediate):**
  - State BOOT.
  - `fetch_addr_o`=RESET_PC.
  - `fetch_req_o`, `inst_valid_o`, `flush_o`, `stall_o`, `misalign_o` all 0.
  - Flush counter 0.
- **BOOT:**
  - Lasts exactly one cycle after reset release. `fetch_req_o`=0.
  - `jump_en_i` and `hold_flag_i` are ignored.
  - Moves to RUN.
- **RUN, priority: jump > hold > memory wait > advance.**
  - **Jump** (`jump_en_i`=1):
    - `flush_o`=1 (combinational) and `fetch_req_o`=0.
    - PC <= {`jump_addr_i`[31:2], 2'b00}.
    - If FLUSH_CYCLES>1: state FLUSH, counter <= FLUSH_CYCLES-2. Otherwise stay in RUN.
    - `hold_flag_i` is ignored that cycle.
  - **Hold** (`hold_flag_i`=1, no jump): `fetch_req_o`=0, `stall_o`=1, PC holds.
  - **Otherwise:** `fetch_req_o`=1.
    - `fetch_gnt_i`=1: PC <= PC+4, `inst_valid_o`=1.
    - `fetch_gnt_i`=0: `stall_o`=1, PC holds, `inst_valid_o`=0.
- **FLUSH:**
  - `flush_o`=1, `fetch_req_o`=0, `stall_o`=0. `hold_flag_i` is ignored.
  - Counter 0 -> RUN; otherwise decrement.
  - A new `jump_en_i` in FLUSH reloads PC and counter. The redirect restarts and flush stays high.
- **Output gating:**
  - `inst_valid_o` = `fetch_req_o` & `fetch_gnt_i` & ~`flush_o`.
  - `fetch_gnt_i` with `fetch_req_o`=0 is ignored.
- **Arithmetic:**
  - PC increment is modulo 2^32: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
  - PC[1:0] is always 2'b00.

## Timing
- Redirect latency: `jump_en_i` high in cycle J.
  - `fetch_addr_o`=target from J+1.
  - First request at the target in cycle J+FLUSH_CYCLES.
- `flush_o` is high for exactly FLUSH_CYCLES consecutive cycles per isolated redirect.
- Hold and memory-wait stall have zero latency: combinational from `hold_flag_i` / `fetch_gnt_i`.
- No combinational path from `fetch_gnt_i` to `fetch_req_o`.
- Reset asserted mid-FLUSH or mid-wait: all outputs return to reset values immediately. A pending redirect is discarded.

## Configuration
- `PC_MISALIGN_TRAP_EN` defined:
  - A jump with `jump_addr_i`[1:0]!=0 does not redirect. State goes to TRAP and PC holds the faulting instruction's successor address.
  - TRAP: `misalign_o`=1, `stall_o`=1, `fetch_req_o`=0, `flush_o`=0. All inputs are ignored until reset.
- Not defined:
  - `misalign_o` port is absent and TRAP does not exist.
  - Low bits of `jump_addr_i` are silently cleared.

## Test plan
- Reset release, `fetch_gnt_i`=1 constant -> cycle 1 `fetch_req_o`=0. `fetch_addr_o` then reads 0x0, 0x4, 0x8, 0xC with `inst_valid_o`=1.
- `jump_en_i`=1, `jump_addr_i`=0x100 in cycle J with FLUSH_CYCLES=2 -> `flush_o`=1 in J and J+1, `fetch_req_o`=0 in both. In J+2, `fetch_req_o`=1 at 0x100.
- `hold_flag_i`=1 and `jump_en_i`=1 together, target 0x40 -> jump wins, `stall_o`=0, `fetch_addr_o`=0x40 next cycle. Then `hold_flag_i` alone for 3 cycles -> PC frozen at 0x40, `stall_o`=1.
- PC=0xFFFF_FFFC, gnt held low 2 cycles then high -> `stall_o`=1 for 2 cycles, PC stays. After the grant, PC=0x0000_0000.
- With macro, jump to 0x102 -> `misalign_o`=1 next cycle and sticky, `fetch_req_o`=0. Without macro, the same stimulus -> PC=0x100, `flush_o` for 2 cycles.
- `rst` driven low asynchronously in the middle of a FLUSH, then released -> outputs reset immediately with no clock edge. Then BOOT for one cycle and fetch resumes at RESET_PC.
